hilo_muldiv: RTL and testbench
==============================

// Module: hilo_muldiv
// PURPOSE
// - Iterative multiply/divide unit with an integrated HI/LO result register pair for the EX stage.
// - Replaces the divide-only HI/LO holding register: signed and unsigned MUL and DIV, MTHI/MTLO writes,
//   gated MFHI/MFLO reads, and a busy/done handshake so the hazard unit can stall on HI/LO reads.
// - One operation in flight; results land atomically in HI/LO at completion.
// PARAMETERS
// - WIDTH  32  operand width; HI and LO are WIDTH bits each, the product/quotient pair is 2*WIDTH.
// PORTS
// - clk     in   1        clock, rising edge
// - reset   in   1        synchronous, active-high; clears all state
// - start   in   1        launch op with src_a/src_b; accepted only when busy=0
// - op      in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
// - src_a   in   WIDTH    multiplicand / dividend
// - src_b   in   WIDTH    multiplier / divisor
// - mthi    in   1        write wr_data to HI
// - mtlo    in   1        write wr_data to LO
// - wr_data in   WIDTH    MTHI/MTLO data
// - rd_hi   in   1        enable hi_out
// - rd_lo   in   1        enable lo_out
// - hi_out  out  WIDTH    HI when rd_hi=1, else 0 (combinational)
// - lo_out  out  WIDTH    LO when rd_lo=1, else 0 (combinational)
// - busy    out  1        op in progress; hazard unit stalls MFHI/MFLO/new MUL/DIV while high
// - done    out  1        one-cycle pulse, HI/LO hold the new result this cycle
// BEHAVIOUR
// - Reset: HI=0, LO=0, state IDLE, count=0, busy=0, done=0; aborts any op in flight, HI/LO not written.
// - FSM IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 latches |a|,|b| (abs only for signed ops), result signs and op; count=0; -> RUN.
//   RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; after WIDTH steps -> FIX.
//   FIX: sign correction, then HI/LO written at the end of the cycle; -> IDLE; done=1 the next cycle.
// - Timing: start sampled at edge k -> busy=1 for cycles k+1 .. k+WIDTH+1; done=1 and busy=0
//   in cycle k+WIDTH+2. Back-to-back start is allowed in the done cycle.
// - MUL: {HI,LO} = 2*WIDTH-bit product; signed result = two's complement of the unsigned product when signs differ.
// - DIV: LO = quotient, HI = remainder. Signed: quotient truncates toward zero, remainder takes the dividend's sign.
//   MIN_INT / -1 -> LO=MIN_INT, HI=0 (falls out of the unsigned path, no special case).
// - Divide by zero (either signedness): LO = all ones, HI = src_a unchanged; same latency, no exception.
// - start while busy: ignored. mthi/mtlo while busy: ignored (HI/LO are owned by the op in flight).
// - start and mthi/mtlo in the same IDLE cycle: start wins, the writes are dropped.
// - mthi and mtlo together: both written in the same edge. HI/LO keep their values indefinitely otherwise.
// - Reads are combinational from the architectural HI/LO; mid-op reads return the pre-op values.
// STRUCTURE
// - Package hilo_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), FSM state enum
//   (ST_IDLE, ST_RUN, ST_FIX), and a log2 width constant for the step counter.
// - Sub-module muldiv_iter_core: the RUN-phase datapath, i.e. the 2*WIDTH accumulator plus shift-add
//   and shift-subtract steps, selected by an is_div input.
// - Top level holds the FSM, abs/sign-fix logic, HI/LO registers, MT writes and read gating.
// TESTING (WIDTH=32)
// - MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at start+34; HI=0xFFFFFFFE, LO=0x00000001.
// - MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
// - DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
// - During a busy DIVU 100/7: pulse mthi(0xAAAA), start and read -> writes and start ignored, reads return
//   the old HI; final result LO=14, HI=2.
// - reset at RUN step 10 -> busy=0 next cycle, HI=LO=0, no done pulse; a new start then completes normally.
// - Idle cycle with mthi=mtlo=1, wr_data=0x1234 -> HI=LO=0x1234; with rd_hi=0, hi_out=0 regardless of HI.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package hilo_pkg;

    localparam int HILO_WIDTH = 32;
    localparam int CNT_W      = $clog2(HILO_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - EX-stage bus between the pipeline and the HI/LO multiply/divide unit
interface hilo_muldiv_if
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wr_data;
    logic             rd_hi;
    logic             rd_lo;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wr_data, rd_hi, rd_lo,
        input  hi_out, lo_out, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wr_data, rd_hi, rd_lo,
        output hi_out, lo_out, busy, done
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one-bit-per-cycle shift-add / restoring shift-subtract accumulator
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    // Low half starts as multiplier/dividend; upper half collects partial product/remainder.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_i} : '0);
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, b_i};
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
        end else if (step_i) begin
            if (is_div_i) begin
                if (!diff[WIDTH]) begin
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative MUL/DIV unit owning the architectural HI/LO pair
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    hilo_muldiv_if.slave   bus
);
    localparam int CW = (WIDTH == HILO_WIDTH) ? CNT_W : $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    op_e                op_q, op_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   b_abs_q, b_abs_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    op_e                op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               core_load, core_step;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   quo, rem;

    assign op_in = op_e'(bus.op);
    assign a_neg = op_is_signed(op_in) & bus.src_a[WIDTH-1];
    assign b_neg = op_is_signed(op_in) & bus.src_b[WIDTH-1];
    assign a_abs = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs = b_neg ? -bus.src_b : bus.src_b;
    assign quo   = acc[WIDTH-1:0];
    assign rem   = acc[2*WIDTH-1:WIDTH];

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (op_is_div(op_q)),
        .a_i      (a_abs),
        .b_i      (b_abs_q),
        .acc_o    (acc)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        divz_d    = divz_q;
        a_raw_d   = a_raw_q;
        b_abs_d   = b_abs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A start in the same cycle as MTHI/MTLO takes priority and drops the writes.
                if (bus.start) begin
                    core_load = 1'b1;
                    op_d      = op_in;
                    negq_d    = a_neg ^ b_neg;
                    negr_d    = a_neg;
                    divz_d    = (bus.src_b == '0);
                    a_raw_d   = bus.src_a;
                    b_abs_d   = b_abs;
                    count_d   = '0;
                    state_d   = ST_RUN;
                end else begin
                    if (bus.mthi) hi_d = bus.wr_data;
                    if (bus.mtlo) lo_d = bus.wr_data;
                end
            end
            ST_RUN: begin
                core_step = 1'b1;
                count_d   = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_is_div(op_q)) begin
                    if (divz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = negq_q ? -quo : quo;
                        hi_d = negr_q ? -rem : rem;
                    end
                end else begin
                    {hi_d, lo_d} = negq_q ? -acc : acc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= OP_MULTU;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            a_raw_q <= '0;
            b_abs_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            a_raw_q <= a_raw_d;
            b_abs_q <= b_abs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.hi_out = bus.rd_hi ? hi_q : '0;
    assign bus.lo_out = bus.rd_lo ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - self-checking bench for hilo_muldiv against an arithmetic reference
module tb_hilo_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {HI,LO} straight from integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p, q, r;
        sa = a;
        sb = b;
        case (op)
            2'b00: return {32'h0, a} * {32'h0, b};
            2'b01: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) return {a % b, a / b};
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Starts at a negedge with the unit idle; returns at the negedge where done is seen.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit interfere, input string tag);
        int          edges;
        bit          busy_ok;
        logic [31:0] pre_hi, pre_lo;
        pre_hi = m_hi;
        pre_lo = m_lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.rd_hi = 1'b1;
        bus.rd_lo = 1'b1;
        edges   = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        edges = 1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        while (!bus.done && edges < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (interfere && edges == 5) begin
                bus.mthi    = 1'b1;
                bus.mtlo    = 1'b1;
                bus.wr_data = 32'h0000_AAAA;
                bus.start   = 1'b1;
                bus.op      = 2'b00;
                bus.src_a   = 32'd3;
                bus.src_b   = 32'd3;
            end
            @(negedge clk);
            edges++;
            if (edges == 6) begin
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
                bus.start = 1'b0;
                check({tag, " mid_hi"}, bus.hi_out, pre_hi);
                check({tag, " mid_lo"}, bus.lo_out, pre_lo);
            end
        end
        check({tag, " busy_held"}, busy_ok, 1);
        check({tag, " latency"}, edges, 34);
        check({tag, " busy_at_done"}, bus.busy, 0);
        check({tag, " hi"}, bus.hi_out, exp[63:32]);
        check({tag, " lo"}, bus.lo_out, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bit          saw_done;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wr_data = '0;
        bus.rd_hi   = 1'b1;
        bus.rd_lo   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset hi", bus.hi_out, 0);
        check("reset lo", bus.lo_out, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        reset = 1'b0;
        @(negedge clk);

        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h0000_1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mt both hi", bus.hi_out, 32'h1234);
        check("mt both lo", bus.lo_out, 32'h1234);
        bus.rd_hi = 1'b0;
        #1;
        check("gated hi", bus.hi_out, 0);
        check("ungated lo", bus.lo_out, 32'h1234);
        bus.rd_hi = 1'b1;
        m_hi = 32'h1234;
        m_lo = 32'h1234;

        bus.mthi    = 1'b1;
        bus.wr_data = 32'h55;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi only hi", bus.hi_out, 32'h55);
        check("mthi only lo", bus.lo_out, 32'h1234);
        m_hi = 32'h55;

        // mthi raised alongside start: the write must be dropped (seen by the mid-op read).
        bus.mthi    = 1'b1;
        bus.wr_data = 32'hBEEF;
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, "multu_max");
        do_op(2'b01, -32'sd3, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b0, "mult_neg");
        do_op(2'b11, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_neg");
        do_op(2'b10, 32'd7, 32'd0, {32'h0000_0007, 32'hFFFF_FFFF}, 1'b0, "divu_zero");
        do_op(2'b11, -32'sd5, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0, "div_zero");
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, "div_minint");
        do_op(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, "divu_interfere");

        // Abort an op mid-RUN with reset.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort hi", bus.hi_out, 0);
        check("abort lo", bus.lo_out, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", saw_done, 0);
        m_hi = '0;
        m_lo = '0;
        do_op(2'b01, 32'd12345, -32'sd678, ref_op(2'b01, 32'd12345, -32'sd678), 1'b0, "after_abort");

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'h1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, ref_op(rop, ra, rb), 1'b0, $sformatf("rand%0d op%0d", n, rop));
        end

        @(negedge clk);
        check("done pulse", bus.done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
